hazard_sb: RTL

- Parametrised successor to the fixed 3-stage hazard/forward pair.
- Tracks every in-flight register write in a tag pipeline DEPTH stages deep (stage 1 = EX output, stage DEPTH = last stage before register-file write).
- Decides combinationally, from those tags, whether the instruction in ID must stall and which stage feeds each of its NSRC source operands.
- Sits beside stg_id/stg_ex. Drives the stall line to the IA/IF/ID stages and the forwarding mux selects into EX.

---
 rtl/hazard_sb.sv | 106 ++++++++++
 1 files changed

// File: rtl/hazard_sb.sv
// hazard_sb: in-flight register-write tag pipeline producing ID stall and EX forward selects
// Ports:
//   iw_clk            clock, rising edge
//   iw_rst_n          asynchronous active-low reset, clears every tag
//   iw_issue_valid    ID holds a valid instruction
//   iw_issue_we       issuing instruction writes a register
//   iw_issue_tgt      target register of the issuing instruction
//   iw_issue_is_load  issuing instruction is a memory load
//   iw_src_addr       NSRC source addresses, source i at [i*REG_AW +: REG_AW]
//   iw_src_used       per-source read flag
//   iw_flush          kill the issuing instruction (stage 1 takes a bubble)
//   ow_stall          hold IA/IF/ID this cycle
//   ow_fwd_sel        per source, SELW bits: 0 = register file, k = stage k result
//   ow_occ            registered count of valid writing tags in stages 1..DEPTH
module hazard_sb #(
   parameter int REG_AW     = 4,
   parameter int NSRC       = 2,
   parameter int DEPTH      = 4,
   parameter int ALU_READY  = 1,
   parameter int LOAD_READY = 3,
   parameter int ZERO_REG   = 1,
   parameter int SELW       = $clog2(DEPTH + 1)
) (
   input  logic                   iw_clk,
   input  logic                   iw_rst_n,
   input  logic                   iw_issue_valid,
   input  logic                   iw_issue_we,
   input  logic [REG_AW-1:0]      iw_issue_tgt,
   input  logic                   iw_issue_is_load,
   input  logic [NSRC*REG_AW-1:0] iw_src_addr,
   input  logic [NSRC-1:0]        iw_src_used,
   input  logic                   iw_flush,
   output logic                   ow_stall,
   output logic [NSRC*SELW-1:0]   ow_fwd_sel,
   output logic [SELW-1:0]        ow_occ
);

   // array index k-1 holds stage k (stage 1 = EX output)
   logic [DEPTH-1:0]             v_q, v_d, we_q, we_d, ld_q, ld_d;
   logic [DEPTH-1:0][REG_AW-1:0] tgt_q, tgt_d;
   logic [SELW-1:0]              occ_q, occ_d;
   logic [NSRC-1:0]              req;
   logic                         issue_ok;

   for (genvar i = 0; i < NSRC; i++) begin : g_src
      logic [REG_AW-1:0] src;
      logic [SELW-1:0]   sel;
      logic              r;
      assign src = iw_src_addr[i*REG_AW +: REG_AW];
      // scan oldest to youngest so the youngest match is the last one written
      always_comb begin
         sel = '0;
         r   = 1'b0;
         for (int k = DEPTH; k >= 1; k--)
            if (v_q[k-1] && we_q[k-1] && tgt_q[k-1] == src && iw_src_used[i] &&
                !(ZERO_REG != 0 && src == '0)) begin
               r   = k < (ld_q[k-1] ? LOAD_READY : ALU_READY);
               sel = r ? '0 : SELW'(k);
            end
      end
      assign req[i]                      = r;
      assign ow_fwd_sel[i*SELW +: SELW] = sel;
   end

   assign ow_stall = iw_issue_valid && |req;
   // flush kills the issue even while stalled; a stall always inserts a bubble
   assign issue_ok = iw_issue_valid && !ow_stall && !iw_flush;

   always_comb begin
      v_d   = v_q;
      we_d  = we_q;
      ld_d  = ld_q;
      tgt_d = tgt_q;
      for (int k = DEPTH - 1; k > 0; k--) begin
         v_d[k]   = v_q[k-1];
         we_d[k]  = we_q[k-1];
         ld_d[k]  = ld_q[k-1];
         tgt_d[k] = tgt_q[k-1];
      end
      v_d[0]   = issue_ok;
      we_d[0]  = iw_issue_we;
      ld_d[0]  = iw_issue_is_load;
      tgt_d[0] = iw_issue_tgt;
      occ_d    = '0;
      for (int k = 0; k < DEPTH; k++)
         occ_d = occ_d + SELW'(v_d[k] && we_d[k]);
   end

   always_ff @(posedge iw_clk or negedge iw_rst_n)
      if (!iw_rst_n) begin
         v_q   <= '0;
         we_q  <= '0;
         ld_q  <= '0;
         tgt_q <= '0;
         occ_q <= '0;
      end else begin
         v_q   <= v_d;
         we_q  <= we_d;
         ld_q  <= ld_d;
         tgt_q <= tgt_d;
         occ_q <= occ_d;
      end

   assign ow_occ = occ_q;

endmodule
